// File: rtl/debounce_event_arbiter.sv
// N-channel debouncer sharing one sample-tick prescaler, feeding a round-robin
// event arbiter with a valid/ready output. Define EVT_FALL_EN to also queue falling events.
module debounce_event_arbiter #(
   parameter int N              = 4,
   parameter int IDW            = 2,
   parameter int TICK_DIV       = 1000,
   parameter int STABLE_SAMPLES = 4
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic [N-1:0]   in,
   output logic [N-1:0]   level,
   output logic           evt_valid,
   input  logic           evt_ready,
   output logic [IDW-1:0] evt_id,
   output logic           evt_rise,
   output logic [N-1:0]   ovf,
   input  logic           ovf_clr
);
   localparam int CW = $clog2(STABLE_SAMPLES) + 1;
   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0]  CNT_LAST   = CW'(STABLE_SAMPLES - 1);
   localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [IDW-1:0] ID_LAST    = IDW'(N - 1);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_OFFER = 1'b1} state_t;

   logic [N-1:0]   r_sync1;
   logic [N-1:0]   r_sync2;
   logic [N-1:0]   r_level;
   logic [N-1:0]   r_pend;
   logic [N-1:0]   r_ovf;
   logic [PW-1:0]  r_presc;
   logic [CW-1:0]  r_cnt [N];
   logic [IDW-1:0] r_ptr;
   logic [IDW-1:0] r_evt_id;
   state_t         r_state;
   state_t         w_state_nxt;
   logic           w_tick;
   logic           w_load;
   logic [IDW-1:0] w_grant;
   logic [IDW-1:0] w_idx;
   logic [N-1:0]   w_commit;
   logic [N-1:0]   w_evt_set;
   logic [N-1:0]   w_load_clr;

   // Two-flop synchronizer for the raw pad inputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_tick = (r_presc == PRESC_LAST);

   // Shared sample-tick prescaler.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + PW'(1);
      end
   end

   // A commit is the tick on which the last required differing sample arrives.
   always_comb begin
      w_commit = '0;
      for (int i = 0; i < N; i++) begin
         if (w_tick && (r_sync2[i] != r_level[i]) && (r_cnt[i] == CNT_LAST)) begin
            w_commit[i] = 1'b1;
         end else begin
            w_commit[i] = 1'b0;
         end
      end
   end

`ifdef EVT_FALL_EN
   assign w_evt_set = w_commit;
`else
   assign w_evt_set = w_commit & ~r_level;
`endif

   // Per-channel stability counters and debounced levels.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_level <= '0;
         for (int i = 0; i < N; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (w_tick) begin
               if (r_sync2[i] == r_level[i]) begin
                  r_cnt[i] <= '0;
               end else if (r_cnt[i] == CNT_LAST) begin
                  r_level[i] <= ~r_level[i];
                  r_cnt[i]   <= '0;
               end else begin
                  r_cnt[i] <= r_cnt[i] + CW'(1);
               end
            end
         end
      end
   end

   // Round-robin search: scan offsets high to low so the nearest pending index from ptr wins.
   always_comb begin
      w_grant = '0;
      w_idx   = '0;
      for (int j = N - 1; j >= 0; j--) begin
         w_idx = IDW'((int'(r_ptr) + j) % N);
         if (r_pend[w_idx]) begin
            w_grant = w_idx;
         end
      end
   end

   // Arbiter next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (|r_pend) begin
               w_load      = 1'b1;
               w_state_nxt = ST_OFFER;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_OFFER: begin
            if (evt_ready) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_OFFER;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_load_clr = w_load ? (N'(1) << w_grant) : '0;

   // Pending bits and sticky overflow; a same-cycle commit beats both the load clear and ovf_clr.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pend <= '0;
         r_ovf  <= '0;
      end else begin
         r_pend <= (r_pend & ~w_load_clr) | w_evt_set;
         r_ovf  <= (r_ovf & ~{N{ovf_clr}}) | (w_evt_set & r_pend & ~w_load_clr);
      end
   end

   // Arbiter state, offered id and round-robin pointer.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_evt_id <= '0;
         r_ptr    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_evt_id <= w_grant;
         end
         if ((r_state == ST_OFFER) && evt_ready) begin
            r_ptr <= (r_evt_id == ID_LAST) ? '0 : r_evt_id + IDW'(1);
         end
      end
   end

`ifdef EVT_FALL_EN
   logic [N-1:0] r_dir;
   logic         r_evt_rise;

   // Direction of each pending event (newest wins) and the direction latched into the offer.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_dir      <= '0;
         r_evt_rise <= 1'b0;
      end else begin
         r_dir <= (r_dir & ~w_evt_set) | (w_evt_set & ~r_level);
         if (w_load) begin
            r_evt_rise <= r_dir[w_grant];
         end
      end
   end

   assign evt_rise = r_evt_rise;
`else
   assign evt_rise = 1'b1;
`endif

   assign level     = r_level;
   assign evt_valid = (r_state == ST_OFFER);
   assign evt_id    = r_evt_id;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_debounce_event_arbiter.sv
// Directed bench for debounce_event_arbiter (N=4, TICK_DIV=4, STABLE_SAMPLES=3); expectations
// follow the EVT_FALL_EN setting of the build.
module tb_debounce_event_arbiter;
   logic       clock;
   logic       reset_n;
   logic [3:0] in;
   logic [3:0] level;
   logic       evt_valid;
   logic       evt_ready;
   logic [1:0] evt_id;
   logic       evt_rise;
   logic [3:0] ovf;
   logic       ovf_clr;
   int         checks;
   int         failures;

   debounce_event_arbiter #(
      .N(4), .IDW(2), .TICK_DIV(4), .STABLE_SAMPLES(3)
   ) dut (
      .clock(clock), .reset_n(reset_n), .in(in), .level(level),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
      .evt_rise(evt_rise), .ovf(ovf), .ovf_clr(ovf_clr)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, ending on the following falling edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         @(negedge clock);
      end
   endtask

   // After this, cycle count 0: prescaler at 0, first tick on edge 4.
   task automatic do_reset();
      reset_n   = 1'b0;
      in        = 4'b0000;
      evt_ready = 1'b0;
      ovf_clr   = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic check_evt(input string tag, input logic [1:0] id, input logic rise);
      check({tag, "_valid"}, evt_valid, 1'b1);
      check({tag, "_id"}, evt_id, id);
      check({tag, "_rise"}, evt_rise, rise);
   endtask

   initial begin
      clock    = 1'b0;
      checks   = 0;
      failures = 0;
      do_reset();
      check("rst_level", level, 4'b0000);
      check("rst_valid", evt_valid, 1'b0);
      check("rst_id", evt_id, 2'd0);
      check("rst_ovf", ovf, 4'b0000);
`ifdef EVT_FALL_EN
      check("rst_rise", evt_rise, 1'b0);
`else
      check("rst_rise", evt_rise, 1'b1);
`endif

      // Glitch: ch0 high for two ticks (4, 8), then low; its counter must fall back to 0.
      in = 4'b0001;
      step(8);
      check("glitch_mid_level", level, 4'b0000);
      in = 4'b0000;
      step(8);
      check("glitch_level", level, 4'b0000);
      check("glitch_valid", evt_valid, 1'b0);

      // Round-robin: ch0, ch2, ch3 rise at cycle 16; commit on tick 28.
      in = 4'b1101;
      evt_ready = 1'b1;
      step(11);
      check("rr_no_early_commit", level, 4'b0000);
      step(1);
      check("rr_level", level, 4'b1101);
      check("rr_valid_pre", evt_valid, 1'b0);
      step(1);
      check_evt("rr_ev0", 2'd0, 1'b1);
      step(1);
      check("rr_gap0", evt_valid, 1'b0);
      step(1);
      check_evt("rr_ev2", 2'd2, 1'b1);
      step(1);
      check("rr_gap1", evt_valid, 1'b0);
      step(1);
      check_evt("rr_ev3", 2'd3, 1'b1);
      step(1);
      check("rr_gap2", evt_valid, 1'b0);
      step(2);

      // ch0 and ch3 fall together at cycle 36 (commit 48), then rise again (commit 64).
      in = 4'b0100;
      step(12);
      check("fall03_level", level, 4'b0100);
      step(1);
`ifdef EVT_FALL_EN
      check_evt("fall03_ev0", 2'd0, 1'b0);
      step(2);
      check_evt("fall03_ev3", 2'd3, 1'b0);
      step(1);
`else
      check("fall03_no_evt", evt_valid, 1'b0);
      step(3);
`endif
      in = 4'b1101;
      step(12);
      check("wrap_level", level, 4'b1101);
      step(1);
      check_evt("wrap_ev0", 2'd0, 1'b1);
      step(2);
      check_evt("wrap_ev3", 2'd3, 1'b1);
      step(1);
      check("wrap_idle", evt_valid, 1'b0);

      // Clean step on ch1 with the consumer stalled, then released.
      do_reset();
      in = 4'b0010;
      step(11);
      check("step_level_pre", level, 4'b0000);
      step(1);
      check("step_level", level, 4'b0010);
      check("step_valid_pre", evt_valid, 1'b0);
      step(1);
      check_evt("step_ev", 2'd1, 1'b1);
      step(2);
      check_evt("step_hold", 2'd1, 1'b1);
      evt_ready = 1'b1;
      step(1);
      check("step_done", evt_valid, 1'b0);
      step(4);
      check("step_single", evt_valid, 1'b0);
      check("step_level_end", level, 4'b0010);
      check("step_ovf", ovf, 4'b0000);

      // Backpressure on ch2: offer held while ch2 falls (28) and rises again (40).
      do_reset();
      in = 4'b0100;
      step(13);
      check_evt("bp_offer", 2'd2, 1'b1);
      step(3);
      in = 4'b0000;
      step(12);
      check("bp_fall_level", level, 4'b0000);
      check_evt("bp_hold1", 2'd2, 1'b1);
      check("bp_ovf0", ovf, 4'b0000);
      in = 4'b0100;
      step(12);
      check("bp_rise_level", level, 4'b0100);
      check_evt("bp_hold2", 2'd2, 1'b1);
`ifdef EVT_FALL_EN
      check("bp_ovf1", ovf, 4'b0100);
`else
      check("bp_ovf1", ovf, 4'b0000);
`endif
      evt_ready = 1'b1;
      step(1);
      check("bp_gap", evt_valid, 1'b0);
      step(1);
      check_evt("bp_second", 2'd2, 1'b1);
      step(1);
      check("bp_done", evt_valid, 1'b0);
      step(1);
      check("bp_idle", evt_valid, 1'b0);
      ovf_clr = 1'b1;
      step(1);
      ovf_clr = 1'b0;
      check("bp_ovf_clr", ovf, 4'b0000);

      // Asynchronous reset while an event is offered.
      do_reset();
      in = 4'b0010;
      step(13);
      check("mid_valid_pre", evt_valid, 1'b1);
      check("mid_level_pre", level, 4'b0010);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_async_valid", evt_valid, 1'b0);
      check("mid_async_level", level, 4'b0000);
      check("mid_async_ovf", ovf, 4'b0000);
      in = 4'b0000;
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      evt_ready = 1'b1;
      step(16);
      check("mid_no_stale", evt_valid, 1'b0);
      check("mid_level_post", level, 4'b0000);

      // ch1 rises then falls: the fall makes an event only with EVT_FALL_EN.
      do_reset();
      evt_ready = 1'b1;
      in = 4'b0010;
      step(13);
      check_evt("rf_rise", 2'd1, 1'b1);
      step(3);
      in = 4'b0000;
      step(12);
      check("rf_level", level, 4'b0000);
      step(1);
`ifdef EVT_FALL_EN
      check_evt("rf_fall", 2'd1, 1'b0);
`else
      check("rf_no_fall", evt_valid, 1'b0);
`endif
      step(1);
      check("rf_idle", evt_valid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
